// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: byte handshake plus bit-select/qualifier outputs of the UART transmit sequencer.
interface uart_tx_ctrl_if;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       tx_done;
   logic [3:0] sel;
   logic [7:0] data_q;
   logic       force_high;
   modport master (output tx_start, tx_data, input tx_ready, tx_done, sel, data_q, force_high);
   modport slave  (input tx_start, tx_data, output tx_ready, tx_done, sel, data_q, force_high);
endinterface

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit sequencer; times each bit and drives the bit-select mux and force-high qualifier.
module uart_tx_ctrl #(
   parameter int CLKS_PER_BIT = 868,
   parameter int CNT_W        = 16
) (
   input logic           clk,
   input logic           rst_n,
   uart_tx_ctrl_if.slave tx
);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             tc;
   assign tc = cnt == CNT_W'(CLKS_PER_BIT - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         tx.sel        <= '0;
         tx.data_q     <= '0;
         tx.force_high <= 1'b1;
         tx.tx_ready   <= 1'b1;
         tx.tx_done    <= 1'b0;
      end else begin
         tx.tx_done <= 1'b0;
         cnt        <= tc ? '0 : cnt + 1'b1;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (tx.tx_start) begin
                  state         <= START;
                  tx.data_q     <= tx.tx_data;
                  tx.sel        <= '0;
                  tx.force_high <= 1'b0;
                  tx.tx_ready   <= 1'b0;
               end
            end
            START: if (tc) begin
               state  <= DATA;
               tx.sel <= 4'd1;
            end
            DATA: if (tc) begin
               if (tx.sel == 4'd8) begin
                  state         <= STOP;
                  tx.sel        <= 4'd9;
                  tx.force_high <= 1'b1;
               end else
                  tx.sel <= tx.sel + 4'd1;
            end
            STOP: if (tc) begin
               state       <= IDLE;
               tx.sel      <= '0;
               tx.tx_done  <= 1'b1;
               tx.tx_ready <= 1'b1;
            end
            default: begin
               state         <= IDLE;
               tx.sel        <= '0;
               tx.force_high <= 1'b1;
               tx.tx_ready   <= 1'b1;
            end
         endcase
      end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: frame-level model checked every cycle on two instances (4 and 2 clocks per bit), plus literal pins.
module tb_uart_tx_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   always #5 clk = ~clk;

   uart_tx_ctrl_if i4 ();
   uart_tx_ctrl_if i2 ();
   uart_tx_ctrl #(.CLKS_PER_BIT(4), .CNT_W(16)) dut4 (.clk(clk), .rst_n(rst_n), .tx(i4.slave));
   uart_tx_ctrl #(.CLKS_PER_BIT(2), .CNT_W(16)) dut2 (.clk(clk), .rst_n(rst_n), .tx(i2.slave));

   typedef struct packed {
      logic       ready;
      logic       done;
      logic       fh;
      logic       line;
      logic [3:0] sel;
      logic [7:0] dq;
   } exp_t;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic mux(input logic [3:0] s, input logic [7:0] d);
      return s == 4'd0 ? 1'b0 : s <= 4'd8 ? d[3'(s - 4'd1)] : 1'b1;
   endfunction

   // Outputs k cycles after an accepting edge, from the frame rules alone: bit = k / cpb.
   function automatic exp_t model(input int cpb, input bit busy, input int k, input logic [7:0] b);
      exp_t x;
      int   bt;
      x.dq = b;
      if (!busy || k == 10 * cpb) begin
         x.ready = 1'b1;
         x.done  = busy;
         x.fh    = 1'b1;
         x.line  = 1'b1;
         x.sel   = 4'd0;
      end else begin
         bt      = k / cpb;
         x.ready = 1'b0;
         x.done  = 1'b0;
         x.fh    = bt == 9;
         x.sel   = 4'(bt);
         x.line  = bt == 0 ? 1'b0 : bt == 9 ? 1'b1 : b[bt-1];
      end
      return x;
   endfunction

   int         n = 0;
   logic       s_start [2];
   logic [7:0] s_data  [2];
   always @(posedge clk) begin
      n          <= n + 1;
      s_start[0] <= i4.tx_start;
      s_data[0]  <= i4.tx_data;
      s_start[1] <= i2.tx_start;
      s_data[1]  <= i2.tx_data;
   end

   bit         bz  [2] = '{0, 0};
   int         e   [2] = '{0, 0};
   logic [7:0] byt [2] = '{8'h00, 8'h00};

   initial forever begin
      exp_t x;
      exp_t a;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            bz[i]  = 0;
            byt[i] = 8'h00;
         end else if (!bz[i] && s_start[i]) begin
            bz[i]  = 1;
            e[i]   = n;
            byt[i] = s_data[i];
         end
         x = model(i == 0 ? 4 : 2, bz[i], n - e[i], byt[i]);
         if (bz[i] && n - e[i] >= 10 * (i == 0 ? 4 : 2)) bz[i] = 0;
         a = i == 0 ? '{i4.tx_ready, i4.tx_done, i4.force_high, i4.force_high | mux(i4.sel, i4.data_q), i4.sel, i4.data_q}
                    : '{i2.tx_ready, i2.tx_done, i2.force_high, i2.force_high | mux(i2.sel, i2.data_q), i2.sel, i2.data_q};
         chk($sformatf("m%0d_ready", i), int'(a.ready), int'(x.ready));
         chk($sformatf("m%0d_done", i), int'(a.done), int'(x.done));
         chk($sformatf("m%0d_force_high", i), int'(a.fh), int'(x.fh));
         chk($sformatf("m%0d_line", i), int'(a.line), int'(x.line));
         chk($sformatf("m%0d_sel", i), int'(a.sel), int'(x.sel));
         chk($sformatf("m%0d_data_q", i), int'(a.dq), int'(x.dq));
      end
   end

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   function automatic int line4();
      return int'(i4.force_high | mux(i4.sel, i4.data_q));
   endfunction

   function automatic int line2();
      return int'(i2.force_high | mux(i2.sel, i2.data_q));
   endfunction

   task automatic wait_done4(input string nm, output int cyc);
      cyc = 0;
      while (!i4.tx_done && cyc < 60) begin
         tick();
         cyc++;
      end
      chk({nm, "_done_seen"}, int'(i4.tx_done), 1);
   endtask

   int ln [45];
   int dn [45];
   int pat [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
   int cnt;
   int cyc;

   initial begin
      i4.tx_start = 1'b0;
      i4.tx_data  = 8'h00;
      i2.tx_start = 1'b0;
      i2.tx_data  = 8'h00;
      repeat (3) tick();
      chk("rst_sel", int'(i4.sel), 0);
      chk("rst_force_high", int'(i4.force_high), 1);
      chk("rst_ready", int'(i4.tx_ready), 1);
      chk("rst_done", int'(i4.tx_done), 0);
      rst_n = 1'b1;
      tick();

      // single 8'hA5 frame, one-cycle start
      i4.tx_start = 1'b1;
      i4.tx_data  = 8'hA5;
      tick();
      i4.tx_start = 1'b0;
      i4.tx_data  = 8'h00;
      for (int k = 0; k < 45; k++) begin
         ln[k] = line4();
         dn[k] = int'(i4.tx_done);
         tick();
      end
      for (int b = 0; b < 10; b++) chk($sformatf("a5_bit%0d", b), ln[4*b+2], pat[b]);
      cnt = 0;
      for (int k = 0; k < 45; k++) cnt += dn[k];
      chk("a5_done_count", cnt, 1);
      chk("a5_done_at_40", dn[40], 1);

      // start ignored while busy
      i4.tx_start = 1'b1;
      i4.tx_data  = 8'h00;
      tick();
      i4.tx_start = 1'b0;
      cnt = 0;
      for (int k = 0; k < 45; k++) begin
         if (k == 13) begin
            chk("busy_sel3", int'(i4.sel), 3);
            i4.tx_start = 1'b1;
            i4.tx_data  = 8'hFF;
         end
         if (k == 14) i4.tx_start = 1'b0;
         cnt += int'(i4.tx_done);
         tick();
      end
      chk("busy_data_q", int'(i4.data_q), 8'h00);
      chk("busy_done_count", cnt, 1);

      // back-to-back frames with tx_start held high
      i4.tx_start = 1'b1;
      i4.tx_data  = 8'h3C;
      tick();
      chk("b2b_first_data_q", int'(i4.data_q), 8'h3C);
      wait_done4("b2b1", cyc);
      chk("b2b1_len", cyc, 40);
      chk("b2b_gap_high", int'(i4.force_high), 1);
      i4.tx_data = 8'hC3;
      tick();
      chk("b2b_second_start_low", int'(i4.force_high), 0);
      chk("b2b_second_data_q", int'(i4.data_q), 8'hC3);
      chk("b2b_second_done_fell", int'(i4.tx_done), 0);
      i4.tx_start = 1'b0;
      wait_done4("b2b2", cyc);
      chk("b2b2_len", cyc, 40);
      chk("b2b2_data_q", int'(i4.data_q), 8'hC3);
      tick();

      // reset mid-DATA at sel=5
      i4.tx_start = 1'b1;
      i4.tx_data  = 8'h5A;
      tick();
      i4.tx_start = 1'b0;
      cyc = 0;
      while (i4.sel != 4'd5 && cyc < 30) begin
         tick();
         cyc++;
      end
      chk("mid_sel5_reached", int'(i4.sel), 5);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_sel", int'(i4.sel), 0);
      chk("mid_rst_force_high", int'(i4.force_high), 1);
      chk("mid_rst_ready", int'(i4.tx_ready), 1);
      chk("mid_rst_done", int'(i4.tx_done), 0);
      chk("mid_rst_data_q", int'(i4.data_q), 0);
      tick();
      tick();
      rst_n = 1'b1;
      cnt = 0;
      for (int k = 0; k < 50; k++) begin
         cnt += int'(i4.tx_done);
         tick();
      end
      chk("mid_rst_no_done", cnt, 0);

      // minimum CLKS_PER_BIT=2, 8'h01
      i2.tx_start = 1'b1;
      i2.tx_data  = 8'h01;
      tick();
      i2.tx_start = 1'b0;
      for (int k = 0; k < 25; k++) begin
         ln[k] = line2();
         dn[k] = int'(i2.tx_done);
         tick();
      end
      for (int k = 0; k < 20; k++)
         chk($sformatf("cpb2_k%0d", k), ln[k], (k == 2 || k == 3 || k >= 18) ? 1 : 0);
      cnt = 0;
      for (int k = 0; k < 25; k++) cnt += dn[k];
      chk("cpb2_done_count", cnt, 1);
      chk("cpb2_done_at_20", dn[20], 1);

      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end
endmodule
